// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder built around one shared 4-bit ripple-carry slice.
// Nibbles are processed LSB first, with the carry chained through a register.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             out_valid_q;

    logic [3:0]       slice_sum_d;
    logic             slice_co_d;
    logic             slice_c3_d;

    // 4-bit ripple-carry slice: returns {carry_out, sum}
    function automatic logic [4:0] slice_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic c);
        return {1'b0, x} + {1'b0, y} + {4'b0000, c};
    endfunction

    // Carry into bit 3 of the slice, needed for signed overflow
    function automatic logic slice_c3(input logic [3:0] x, input logic [3:0] y,
                                      input logic c);
        logic [3:0] low;
        low = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, c};
        return low[3];
    endfunction

    // Shared slice operating on the nibble selected by idx
    always_comb begin
        logic [4:0] res;
        res         = slice_add(a_q[4*idx_q +: 4], b_q[4*idx_q +: 4], carry_q);
        slice_sum_d = res[3:0];
        slice_co_d  = res[4];
        slice_c3_d  = slice_c3(a_q[4*idx_q +: 4], b_q[4*idx_q +: 4], carry_q);
    end

    // Sequencer FSM with registered handshake flags and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                RUN: begin
                    sum_q[4*idx_q +: 4] <= slice_sum_d;
                    carry_q             <= slice_co_d;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= slice_co_d;
                        ovf_q       <= slice_c3_d ^ slice_co_d;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q       <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    // Result stays frozen until the consumer takes it
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= DONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    idx_q       <= '0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized and directed bench for nibble_serial_adder_ctrl, compared against
// a plain-arithmetic reference of the add, its latency and the handshakes.
module tb_nibble_serial_adder_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; stall = cycles out_ready is held low in DONE
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_c, input int stall);
        logic [W:0]   full;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
        int           n;
        int           busy_cnt;
        full   = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_c};
        e_sum  = full[W-1:0];
        e_cout = full[W];
        e_ovf  = (op_a[W-1] == op_b[W-1]) && (e_sum[W-1] != op_a[W-1]);

        check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a = op_a; b = op_b; cin = op_c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        n = 0;
        busy_cnt = 0;
        while (!out_valid && n < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check_val("latency", n, NIB);
        check_val("busy_cycles", busy_cnt, NIB);
        check_val("sum", {16'd0, sum}, {16'd0, e_sum});
        check_val("cout", {31'd0, cout}, {31'd0, e_cout});
        check_val("ovf", {31'd0, ovf}, {31'd0, e_ovf});
        check_val("in_ready_done", {31'd0, in_ready}, 32'd0);

        // A competing request during DONE must not be taken
        out_ready = 1'b0;
        in_valid  = (stall > 0);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("hold_valid", {31'd0, out_valid}, 32'd1);
            check_val("hold_sum", {15'd0, cout, sum}, {15'd0, e_cout, e_sum});
            check_val("hold_ovf", {31'd0, ovf}, {31'd0, e_ovf});
            check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check_val("post_hs_busy", {31'd0, busy}, 32'd0);
        check_val("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_result", {14'd0, ovf, cout, sum}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1);
        run_op(16'h0FFF, 16'h0001, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 2);
        run_op(16'h0000, 16'h0000, 1'b1, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 3);

        // Reset in the middle of RUN discards the operation
        in_valid = 1'b1; a = 16'h9999; b = 16'h6667; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("midrst_result", {14'd0, ovf, cout, sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NIB + 2; k++) begin
            @(negedge clk);
            check_val("midrst_no_output", {31'd0, out_valid}, 32'd0);
        end
        run_op(16'h9999, 16'h6667, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
